aes_key_expand_128: RTL and testbench

- Sequential AES-128 key schedule engine. Expands a 128-bit cipher key into 11 round keys (44 words), producing one word per clock.
- Instantiates 4 aes_sbox instances for SubWord and holds the full schedule in an internal register file.
- A random-access read port serves the round keys to the downstream round datapath.
- Sits between the key-load interface and the AES round pipeline in the GCM core.

---
 rtl/aes_key_expand_128.sv | 168 ++++++++++++++++
 tb/tb_aes_key_expand_128.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expand_128.sv
// AES-128 key schedule engine.
// Expands a 128-bit cipher key into 44 words (11 round keys), one word per clock, and serves
// the finished schedule through a combinational random-access read port.
//
// aes_sbox: combinational AES forward S-box lookup.
//   data_i  - input byte
//   data_o  - substituted byte
//
// aes_key_expand_128:
//   clk        - system clock, rising edge
//   rst        - synchronous active-high reset
//   key_valid  - cipher key present on key
//   key        - cipher key, key[127:96] = w0
//   key_ready  - engine can accept a new key
//   done       - one-cycle pulse when the expansion completes
//   keys_valid - stored schedule complete and readable
//   rk_idx     - round-key index for the read port (0..10)
//   rk_out     - round key rk_idx, zero when not readable or index out of range

module aes_sbox (
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  // Byte 0x00 sits in the top 8 bits.
  localparam logic [2047:0] SboxTable = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  always_comb begin
    data_o = SboxTable[8 * (255 - int'(data_i)) +: 8];
  end

endmodule

module aes_key_expand_128 #(
  parameter int unsigned NR       = 10,
  parameter int unsigned RK_COUNT = NR + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  input  logic [127:0] key,
  output logic         key_ready,
  output logic         done,
  output logic         keys_valid,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_out
);

  localparam int unsigned NumWords = 4 * RK_COUNT;

  typedef enum logic [1:0] {StIdle, StExpand, StReady} state_e;

  state_e      state_q, state_d;
  logic        done_q, done_d;
  logic [5:0]  i_q, i_d;
  logic [7:0]  rcon_q, rcon_d;
  logic [31:0] w_q [NumWords];

  logic        accept;
  logic        expanding;
  logic        last_word;
  logic        round_word;
  logic [31:0] prev_w;
  logic [31:0] rot_w;
  logic [31:0] sub_w;
  logic [31:0] temp_w;
  logic [31:0] new_w;
  logic [5:0]  rd_base;

  assign accept     = key_valid && key_ready;
  assign expanding  = (state_q == StExpand);
  assign last_word  = expanding && (i_q == 6'(NumWords - 1));
  assign round_word = (i_q[1:0] == 2'b00);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      done_q  <= 1'b0;
      i_q     <= 6'd4;
      rcon_q  <= 8'h01;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      i_q     <= i_d;
      rcon_q  <= rcon_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    done_d  = last_word;
    i_d     = i_q;
    rcon_d  = rcon_q;
    unique case (state_q)
      StIdle, StReady: begin
        if (key_valid) begin
          state_d = StExpand;
          i_d     = 6'd4;
          rcon_d  = 8'h01;
        end
      end
      StExpand: begin
        i_d = i_q + 6'd1;
        if (round_word) begin
          rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        end
        if (last_word) begin
          state_d = StReady;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs.
  always_comb begin
    key_ready  = (state_q != StExpand);
    keys_valid = (state_q == StReady);
    done       = done_q;
    rk_out     = '0;
    if (keys_valid && (rk_idx <= 4'(NR))) begin
      rk_out = {w_q[rd_base], w_q[rd_base + 6'd1], w_q[rd_base + 6'd2], w_q[rd_base + 6'd3]};
    end
  end

  // Out-of-range indices are clamped so the array is never read past its end.
  assign rd_base = (rk_idx <= 4'(NR)) ? {rk_idx, 2'b00} : 6'd0;

  // Word datapath. The guard keeps the i-1 / i-4 reads in range outside EXPAND.
  assign prev_w = w_q[expanding ? (i_q - 6'd1) : 6'd3];
  assign rot_w  = {prev_w[23:0], prev_w[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .data_i (rot_w[8*b +: 8]),
      .data_o (sub_w[8*b +: 8])
    );
  end

  assign temp_w = round_word ? (sub_w ^ {rcon_q, 24'h0}) : prev_w;
  assign new_w  = w_q[expanding ? (i_q - 6'd4) : 6'd0] ^ temp_w;

  // Schedule storage; never reset, reads are gated by keys_valid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (accept) begin
        w_q[0] <= key[127:96];
        w_q[1] <= key[95:64];
        w_q[2] <= key[63:32];
        w_q[3] <= key[31:0];
      end else if (expanding) begin
        w_q[i_q] <= new_w;
      end
    end
  end

endmodule

// File: tb/tb_aes_key_expand_128.sv
module tb_aes_key_expand_128;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         key_valid = 1'b0;
  logic [127:0] key = '0;
  logic [3:0]   rk_idx = '0;
  logic         key_ready;
  logic         done;
  logic         keys_valid;
  logic [127:0] rk_out;

  localparam logic [127:0] FipsKey  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FipsRk1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FipsRk10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZeroRk1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZeroRk10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  aes_key_expand_128 dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key        (key),
    .key_ready  (key_ready),
    .done       (done),
    .keys_valid (keys_valid),
    .rk_idx     (rk_idx),
    .rk_out     (rk_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int n = 0; n < 8; n++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  function automatic logic [7:0] ref_sbox(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h00;
    for (int x = 1; x < 256; x++) begin
      if (gmul(a, 8'(x)) == 8'h01) inv = 8'(x);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [1407:0] expand_key(input logic [127:0] k);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1407:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {ref_sbox(t[23:16]), ref_sbox(t[15:8]), ref_sbox(t[7:0]), ref_sbox(t[31:24])}
            ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) res[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return res;
  endfunction

  // Transaction-level model: 0 idle, 1 expanding, 2 ready.
  int            m_st = 0;
  int            m_cnt = 0;
  bit            m_done = 1'b0;
  logic [1407:0] m_pend = '0;
  logic [1407:0] m_sched = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_st   <= 0;
      m_done <= 1'b0;
      m_cnt  <= 0;
    end else begin
      m_done <= 1'b0;
      if (key_valid && m_st != 1) begin
        m_pend <= expand_key(key);
        m_st   <= 1;
        m_cnt  <= 0;
      end else if (m_st == 1) begin
        m_cnt <= m_cnt + 1;
        if (m_cnt == 39) begin
          m_st    <= 2;
          m_done  <= 1'b1;
          m_sched <= m_pend;
        end
      end
    end
  end

  function automatic logic [127:0] model_rk(input int idx);
    if (m_st == 2 && idx <= 10) return m_sched[128*idx +: 128];
    return '0;
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("key_ready", 128'(key_ready), 128'(m_st != 1));
      check("keys_valid", 128'(keys_valid), 128'(m_st == 2));
      check("done", 128'(done), 128'(m_done));
      check("rk_out", rk_out, model_rk(int'(rk_idx)));
    end
  end

  // ---------------- stimulus ----------------
  task automatic start_key(input logic [127:0] k);
    @(posedge clk);
    #2;
    key_valid = 1'b1;
    key = k;
  endtask

  // Loops from the accept edge (n=0); lat is the edge count after which done was seen.
  task automatic run_expand(input bit spam, output int lat, output int ready_hi, output int kv_hi);
    lat = -1; ready_hi = 0; kv_hi = 0;
    for (int n = 0; n <= 60; n++) begin
      @(posedge clk);
      #2;
      if (spam && n <= 38) begin
        key_valid = 1'b1;
        key = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        key_valid = 1'b0;
      end
      rk_idx = 4'(n % 16);
      #1;
      if (n > 0 && done) begin
        lat = n;
        break;
      end
      if (n > 0 && key_ready) ready_hi++;
      if (n > 0 && keys_valid) kv_hi++;
    end
    if (lat < 0) $display("FAIL done_timeout: got no done expected done within 60 cycles");
  endtask

  task automatic read_rk(input int idx, input string name, input logic [127:0] exp);
    @(posedge clk);
    #2;
    rk_idx = 4'(idx);
    #1;
    check(name, rk_out, exp);
  endtask

  int lat, ready_hi, kv_hi;

  initial begin
    // Pin the model itself.
    check("model_sbox_00", 128'(ref_sbox(8'h00)), 128'h63);
    check("model_sbox_53", 128'(ref_sbox(8'h53)), 128'hed);
    check("model_fips_rk1", expand_key(FipsKey)[128 +: 128], FipsRk1);

    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("reset_rk0", rk_out, 128'h0);
    check("reset_key_ready", 128'(key_ready), 128'h1);

    // FIPS-197 key.
    start_key(FipsKey);
    run_expand(1'b0, lat, ready_hi, kv_hi);
    check("fips_latency", 128'(lat), 128'd40);
    check("fips_ready_during_expand", 128'(ready_hi), 128'd0);
    read_rk(1, "fips_rk1", FipsRk1);
    read_rk(10, "fips_rk10", FipsRk10);
    read_rk(0, "fips_rk0", FipsKey);
    for (int i = 11; i < 16; i++) read_rk(i, "rk_idx_out_of_range", 128'h0);

    // Restart from READY with the zero key.
    start_key(128'h0);
    run_expand(1'b0, lat, ready_hi, kv_hi);
    check("zero_latency", 128'(lat), 128'd40);
    check("zero_keys_valid_during_expand", 128'(kv_hi), 128'd0);
    read_rk(1, "zero_rk1", ZeroRk1);
    read_rk(10, "zero_rk10", ZeroRk10);

    // Key spam during EXPAND must be ignored.
    start_key(FipsKey);
    run_expand(1'b1, lat, ready_hi, kv_hi);
    check("spam_latency", 128'(lat), 128'd40);
    check("spam_key_ready", 128'(ready_hi), 128'd0);
    read_rk(1, "spam_rk1", FipsRk1);
    read_rk(10, "spam_rk10", FipsRk10);

    // Reset at T+20, then accept the FIPS key.
    start_key(128'h0);
    @(posedge clk);
    #2;
    key_valid = 1'b0;
    repeat (18) @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("abort_key_ready", 128'(key_ready), 128'h1);
    check("abort_keys_valid", 128'(keys_valid), 128'h0);
    check("abort_rk_out", rk_out, 128'h0);
    start_key(FipsKey);
    run_expand(1'b0, lat, ready_hi, kv_hi);
    check("abort_latency", 128'(lat), 128'd40);
    check("abort_keys_valid_before_done", 128'(kv_hi), 128'd0);
    read_rk(1, "abort_rk1", FipsRk1);
    read_rk(10, "abort_rk10", FipsRk10);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
